// File: rtl/instruction_loader_if.sv
// +----------------------------------------------------------------------------+
// | instruction_loader_if : byte-stream, memory-write and status bundle         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface instruction_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [15:0]       word_count;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              cpu_hold;
  logic              done;

  modport master (
    output start, word_count, abort, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done
  );

  modport slave (
    input  start, word_count, abort, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done
  );
endinterface

`default_nettype wire

// File: rtl/instruction_loader.sv
// +----------------------------------------------------------------------------+
// | instruction_loader : assembles little-endian words from a byte stream and   |
// | writes them to instruction memory while holding the core. Revision: 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module instruction_loader #(
  parameter int MEM_WORDS = 256,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_loader_if.slave  bus
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_byte_idx;
  logic [IDX_W-1:0]  r_word_idx;
  logic [IDX_W-1:0]  r_last_idx;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [IDX_W-1:0]  w_last_idx;
  logic              w_xfer;
  logic              w_last_word;
  logic              w_go;

  // Requested count is clamped to the memory depth; stored as the last index
  always_comb begin
    w_last_idx = IDX_W'(MEM_WORDS - 1);
    if ({16'd0, bus.word_count} < 32'(MEM_WORDS)) begin
      w_last_idx = IDX_W'(bus.word_count - 16'd1);
    end
  end

  assign w_go        = bus.start && !bus.abort;
  assign w_xfer      = (r_state == S_COLLECT) && !bus.abort && bus.byte_valid;
  assign w_last_word = (r_word_idx == r_last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_next = (bus.word_count == 16'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (w_xfer && (r_byte_idx == 2'd3)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else begin
          w_next = w_last_word ? S_DONE : S_COLLECT;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx <= 2'd0;
      r_word_idx <= '0;
      r_last_idx <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && (bus.word_count != 16'd0)) begin
            r_last_idx <= w_last_idx;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_wr_addr  <= ADDR_W'(BASE_ADDR);
          end
        end
        S_COLLECT: begin
          if (w_xfer) begin
            r_wr_data[{r_byte_idx, 3'b000} +: 8] <= bus.byte_in;
            r_byte_idx                          <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          // An aborted write leaves the index and address untouched
          if (!bus.abort && !w_last_word) begin
            r_word_idx <= r_word_idx + IDX_W'(1);
            r_wr_addr  <= r_wr_addr + ADDR_W'(4);
            r_byte_idx <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.byte_ready = (r_state == S_COLLECT) && !bus.abort;
  assign bus.wr_en      = (r_state == S_WRITE) && !bus.abort;
  assign bus.done       = (r_state == S_DONE) && !bus.abort;
  assign bus.busy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign bus.cpu_hold   = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_instruction_loader.sv
// +----------------------------------------------------------------------------+
// | tb_instruction_loader : randomized scoreboard bench for instruction_loader  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instruction_loader;

  localparam int MEM_WORDS = 256;
  localparam int BASE_ADDR = 0;
  localparam int ADDR_W    = 32;

  typedef struct packed {
    logic        is_done;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   writes_seen = 0;
  int   last_wr_cyc = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;
  int   xfer_cyc = 0;
  int   word_first_cyc = 0;
  logic [31:0] last_wr_addr = 32'd0;
  ev_t         exp_q[$];
  logic [31:0] prog_q[$];

  instruction_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  instruction_loader #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write/done the DUT presents is matched in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.wr_en) begin
        ev_t e;
        writes_seen++;
        last_wr_cyc  = cyc;
        last_wr_addr = ifc.wr_addr;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", ifc.wr_addr, ifc.wr_data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            checks++; errors++;
            $display("FAIL write_order: got write at 0x%0h expected done pulse", ifc.wr_addr);
          end else begin
            chk("wr_addr", 64'(ifc.wr_addr), 64'(e.addr));
            chk("wr_data", 64'(ifc.wr_data), 64'(e.data));
          end
        end
      end
      if (ifc.done) begin
        ev_t e;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done pulse expected none");
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (!e.is_done) begin
            errors++;
            $display("FAIL done_order: got done expected write addr 0x%0h", e.addr);
          end
        end
      end
    end
  end

  function automatic void push_write(input int idx, input logic [31:0] data);
    ev_t e;
    e.is_done = 1'b0;
    e.addr    = 32'(BASE_ADDR + 4 * idx);
    e.data    = data;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done();
    ev_t e;
    e = '0;
    e.is_done = 1'b1;
    exp_q.push_back(e);
  endfunction

  task automatic pulse_start(input int n);
    ifc.word_count = 16'(n);
    ifc.start      = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic took;
    n = 0; took = 1'b0;
    ifc.byte_in    = b;
    ifc.byte_valid = 1'b1;
    while (!took && n < 50) begin
      @(negedge clk);
      took     = ifc.byte_ready;
      xfer_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    if (!took) begin
      checks++; errors++;
      $display("FAIL byte_timeout: got byte_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic idle_gap(input int g);
    if (g > 0) begin
      ifc.byte_valid = 1'b0;
      ifc.byte_in    = 8'($urandom);
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) begin
      idle_gap((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      send_byte(w[8*k +: 8]);
      if (k == 0) word_first_cyc = xfer_cyc;
    end
    ifc.byte_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference: min(n, MEM_WORDS) words at BASE_ADDR+4*i, then one done pulse
  task automatic load(input int n, input int gap_max);
    int          eff;
    logic [31:0] d;
    eff = (n > MEM_WORDS) ? MEM_WORDS : n;
    if (eff == 0) push_done();
    pulse_start(n);
    if (eff > 0) begin
      chk("busy_loading", 64'(ifc.busy), 64'd1);
      chk("cpu_hold_loading", 64'(ifc.cpu_hold), 64'd1);
    end
    for (int i = 0; i < eff; i++) begin
      d = (i < prog_q.size()) ? prog_q[i] : $urandom;
      push_write(i, d);
      if (i == eff - 1) push_done();
      send_word(d, gap_max);
    end
    drain("load_drained");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_ready"}, 64'(ifc.byte_ready), 64'd0);
    chk({tag, "_wr_en"},      64'(ifc.wr_en),      64'd0);
    chk({tag, "_busy"},       64'(ifc.busy),       64'd0);
    chk({tag, "_cpu_hold"},   64'(ifc.cpu_hold),   64'd0);
    chk({tag, "_done"},       64'(ifc.done),       64'd0);
    chk({tag, "_wr_addr"},    64'(ifc.wr_addr),    64'd0);
    chk({tag, "_wr_data"},    64'(ifc.wr_data),    64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    int n;
    logic [31:0] w0;
    logic [31:0] w1;
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.word_count = 16'd0; ifc.abort = 1'b0;
    ifc.byte_in = 8'd0; ifc.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, back-to-back bytes: write 4 cycles after first transfer
    prog_q = '{32'h00100093};
    load(1, 0);
    chk("t1_wr_latency", 64'(last_wr_cyc - word_first_cyc), 64'd4);

    prog_q = '{32'h00100093, 32'h00208113, 32'h002101B3, 32'h40310233};
    load(4, 0);

    // Three idle cycles mid-word delay the write by three cycles
    push_write(0, 32'h00208113);
    push_done();
    pulse_start(1);
    send_byte(8'h13); word_first_cyc = xfer_cyc;
    send_byte(8'h81);
    idle_gap(3);
    send_byte(8'h20);
    send_byte(8'h00);
    ifc.byte_valid = 1'b0;
    drain("t3_drained");
    chk("t3_wr_latency", 64'(last_wr_cyc - word_first_cyc), 64'd7);

    prog_q.delete();
    load(0, 0);
    chk("zero_done_cycle", 64'(done_cyc), 64'(start_cyc));

    ws = writes_seen;
    load(300, 0);
    chk("clamp_writes", 64'(writes_seen - ws), 64'd256);
    chk("clamp_last_addr", 64'(last_wr_addr), 64'd1020);

    // Abort after two bytes of word 1: only word 0 is written, no done
    w0 = $urandom; w1 = $urandom;
    push_write(0, w0);
    pulse_start(3);
    send_word(w0, 1);
    send_byte(w1[7:0]);
    send_byte(w1[15:8]);
    ifc.byte_valid = 1'b0;
    ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    chk("abort_collect_busy", 64'(ifc.busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_collect_q", 64'(exp_q.size()), 64'd0);
    prog_q = '{32'hDEADBEEF};
    load(1, 0);

    // Abort raised during WRITE suppresses that cycle's strobe
    pulse_start(2);
    send_word($urandom, 0);
    ifc.abort = 1'b1;
    #1;
    chk("abort_write_wr_en", 64'(ifc.wr_en), 64'd0);
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    chk("abort_write_busy", 64'(ifc.busy), 64'd0);
    repeat (4) @(posedge clk);
    #1;

    // Start pulses in COLLECT and in the DONE cycle are ignored
    ws = writes_seen;
    w0 = $urandom; w1 = $urandom;
    push_write(0, w0);
    pulse_start(2);
    send_byte(w0[7:0]);
    send_byte(w0[15:8]);
    ifc.byte_valid = 1'b0;
    pulse_start(7);
    send_byte(w0[23:16]);
    send_byte(w0[31:24]);
    push_write(1, w1);
    push_done();
    send_word(w1, 0);
    @(posedge clk); #1;
    pulse_start(3);
    repeat (10) @(posedge clk);
    #1;
    chk("restart_q", 64'(exp_q.size()), 64'd0);
    chk("restart_writes", 64'(writes_seen - ws), 64'd2);
    chk("restart_busy", 64'(ifc.busy), 64'd0);

    // Asynchronous reset in the WRITE cycle of word 2
    w0 = $urandom; w1 = $urandom;
    push_write(0, w0);
    push_write(1, w1);
    pulse_start(4);
    send_word(w0, 0);
    send_word(w1, 0);
    send_word($urandom, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("async_rst_q", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      prog_q.delete();
      load(n, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
